// File: rtl/output_layer_mac_if.sv
// Handshake and score bus between the activation/weight source and output_layer_mac.
// Beats move on cycles where in_valid && in_ready; the source holds x_in/w_in stable while in_valid is high and not yet accepted.
interface output_layer_mac_if #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 26
);
    logic                        start;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DATA_W-1:0]    x_in;
    logic [10*WEIGHT_W-1:0]      w_in;
    logic                        busy;
    logic                        score_valid;
    logic signed [ACC_W-1:0]     out1, out2, out3, out4, out5;
    logic signed [ACC_W-1:0]     out6, out7, out8, out9, out10;

    modport master (
        output start, in_valid, x_in, w_in,
        input  in_ready, busy, score_valid,
        input  out1, out2, out3, out4, out5, out6, out7, out8, out9, out10
    );

    modport slave (
        input  start, in_valid, x_in, w_in,
        output in_ready, busy, score_valid,
        output out1, out2, out3, out4, out5, out6, out7, out8, out9, out10
    );
endinterface

// File: rtl/output_layer_mac.sv
// Ten-class output-layer multiply-accumulator feeding the argmax stage.
// Define OUTLAYER_SAT_EN to saturate accumulator adds; otherwise they wrap modulo 2^ACC_W.
module output_layer_mac #(
    parameter int N_IN     = 784,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 26
) (
    input  logic                clk,
    input  logic                rst,
    output_layer_mac_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q;
    logic signed [ACC_W-1:0]    acc   [10];
    logic signed [ACC_W-1:0]    acc_d [10];
    logic signed [PROD_W-1:0]   prod  [10];
    logic                       in_ready, busy, score_valid, clear, accept;

`ifdef OUTLAYER_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic signed [ACC_W:0]      sum   [10];
`endif

    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        busy        = 1'b0;
        score_valid = 1'b0;
        clear       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (bus.in_valid && cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                score_valid = 1'b1;
                if (bus.start) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    // Full-width signed product, sign-extended before the add.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            prod[k] = PROD_W'(bus.x_in) * PROD_W'($signed(bus.w_in[WEIGHT_W*k +: WEIGHT_W]));
`ifdef OUTLAYER_SAT_EN
            sum[k] = {acc[k][ACC_W-1], acc[k]}
                   + {{(ACC_W+1-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
            if (sum[k][ACC_W] != sum[k][ACC_W-1])
                acc_d[k] = sum[k][ACC_W] ? ACC_MIN : ACC_MAX;
            else
                acc_d[k] = sum[k][ACC_W-1:0];
`else
            acc_d[k] = acc[k] + {{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int k = 0; k < 10; k++) acc[k] <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                cnt_q <= '0;
                for (int k = 0; k < 10; k++) acc[k] <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
                for (int k = 0; k < 10; k++) acc[k] <= acc_d[k];
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.busy        = busy;
    assign bus.score_valid = score_valid;
    assign bus.out1        = acc[0];
    assign bus.out2        = acc[1];
    assign bus.out3        = acc[2];
    assign bus.out4        = acc[3];
    assign bus.out5        = acc[4];
    assign bus.out6        = acc[5];
    assign bus.out7        = acc[6];
    assign bus.out8        = acc[7];
    assign bus.out9        = acc[8];
    assign bus.out10       = acc[9];
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_output_layer_mac.sv
// Directed bench for output_layer_mac: a 4-beat instance for function/timing and a 4096-beat one for overflow.
module tb_output_layer_mac;
    logic clk, rst;
    logic [1:0] st_small, st_big;
    int errors = 0;
    int checks = 0;

    output_layer_mac_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(26)) b4 ();
    output_layer_mac_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(26)) bk ();

    output_layer_mac #(.N_IN(4), .DATA_W(8), .WEIGHT_W(8), .ACC_W(26)) dut (
        .clk(clk), .rst(rst), .bus(b4), .dbg_state(st_small));
    output_layer_mac #(.N_IN(4096), .DATA_W(8), .WEIGHT_W(8), .ACC_W(26)) dut_big (
        .clk(clk), .rst(rst), .bus(bk), .dbg_state(st_big));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [79:0] w_basic, w_c4, w_all;
    longint ovf_exp;

    initial begin
        w_basic = '0;
        w_basic[7:0]   = 8'd1;
        w_basic[15:8]  = 8'hFF;
        w_basic[79:72] = 8'd127;
        w_c4 = '0;
        w_c4[39:32] = 8'd5;
        w_all = {10{8'h7F}};
`ifdef OUTLAYER_SAT_EN
        ovf_exp = 33554431;
`else
        ovf_exp = -1044480;
`endif
        b4.start = 0; b4.in_valid = 0; b4.x_in = '0; b4.w_in = '0;
        bk.start = 0; bk.in_valid = 0; bk.x_in = '0; bk.w_in = '0;

        // Reset
        rst = 1; step(); step(); rst = 0;
        check("reset_in_ready", b4.in_ready, 0);
        check("reset_busy", b4.busy, 0);
        check("reset_score_valid", b4.score_valid, 0);
        check("reset_out1", b4.out1, 0);
        check("reset_out10", b4.out10, 0);
        check("reset_state", st_small, 0);

        // Beats offered in IDLE without start are ignored
        b4.in_valid = 1; b4.x_in = 8'sd50; b4.w_in = w_basic; step();
        check("idle_no_accept_out1", b4.out1, 0);
        b4.in_valid = 0;

        // Basic
        b4.start = 1; step(); b4.start = 0;
        check("basic_in_ready", b4.in_ready, 1);
        check("basic_busy", b4.busy, 1);
        b4.in_valid = 1; b4.w_in = w_basic;
        b4.x_in = 8'sd1; step();
        check("basic_latency_out1", b4.out1, 1);
        b4.x_in = 8'sd2; step();
        b4.x_in = 8'sd3; step();
        b4.x_in = 8'sd4;
        check("basic_sv_early", b4.score_valid, 0);
        step();
        check("basic_sv", b4.score_valid, 1);
        check("basic_out1", b4.out1, 10);
        check("basic_out2", b4.out2, -10);
        check("basic_out3", b4.out3, 0);
        check("basic_out9", b4.out9, 0);
        check("basic_out10", b4.out10, 1270);
        check("done_in_ready", b4.in_ready, 0);
        check("done_busy", b4.busy, 0);
        check("done_state", st_small, 2);
        b4.x_in = 8'sd99; step(); step();
        check("done_hold_out1", b4.out1, 10);
        check("done_hold_sv", b4.score_valid, 1);
        b4.in_valid = 0;

        // Stall: 3 idle cycles between beats 2 and 3
        b4.start = 1; step(); b4.start = 0;
        check("stall_cleared_out1", b4.out1, 0);
        check("stall_sv_low", b4.score_valid, 0);
        b4.in_valid = 1;
        b4.x_in = 8'sd1; step();
        b4.x_in = 8'sd2; step();
        b4.in_valid = 0; b4.x_in = 8'sd77;
        step(); step(); step();
        check("stall_hold_out1", b4.out1, 3);
        check("stall_hold_out10", b4.out10, 381);
        b4.in_valid = 1;
        b4.x_in = 8'sd3; step();
        b4.x_in = 8'sd4;
        check("stall_sv_step7", b4.score_valid, 0);
        step();
        b4.in_valid = 0;
        check("stall_sv_step8", b4.score_valid, 1);
        check("stall_out1", b4.out1, 10);
        check("stall_out2", b4.out2, -10);
        check("stall_out10", b4.out10, 1270);

        // Restart with start and in_valid together: no beat taken that edge
        b4.start = 1; b4.in_valid = 1; b4.x_in = -8'sd2; b4.w_in = w_c4;
        step(); b4.start = 0;
        check("restart_out1_zero", b4.out1, 0);
        check("restart_out10_zero", b4.out10, 0);
        check("restart_out5_zero", b4.out5, 0);
        check("restart_sv_low", b4.score_valid, 0);
        step(); step(); step();
        check("restart_sv_after3", b4.score_valid, 0);
        check("restart_out5_partial", b4.out5, -30);
        step();
        b4.in_valid = 0;
        check("restart_sv", b4.score_valid, 1);
        check("restart_out5", b4.out5, -40);
        check("restart_out1", b4.out1, 0);
        check("restart_out6", b4.out6, 0);

        // Start during ACCUM is ignored
        b4.start = 1; step(); b4.start = 0;
        b4.in_valid = 1; b4.w_in = w_basic;
        b4.x_in = 8'sd1; step();
        b4.x_in = 8'sd2; step();
        b4.in_valid = 0; b4.start = 1; step(); b4.start = 0;
        check("ign_start_busy", b4.busy, 1);
        check("ign_start_out1", b4.out1, 3);
        b4.in_valid = 1;
        b4.x_in = 8'sd3; step();
        b4.x_in = 8'sd4; step();
        b4.in_valid = 0;
        check("ign_start_sv", b4.score_valid, 1);
        check("ign_start_out1_final", b4.out1, 10);
        check("ign_start_out2_final", b4.out2, -10);
        check("ign_start_out10_final", b4.out10, 1270);

        // Reset in the middle of ACCUM
        b4.start = 1; step(); b4.start = 0;
        b4.in_valid = 1;
        b4.x_in = 8'sd1; step();
        b4.x_in = 8'sd2; step();
        rst = 1; step(); rst = 0;
        check("midrst_out1", b4.out1, 0);
        check("midrst_out10", b4.out10, 0);
        check("midrst_in_ready", b4.in_ready, 0);
        check("midrst_busy", b4.busy, 0);
        check("midrst_sv", b4.score_valid, 0);
        check("midrst_state", st_small, 0);
        step();
        check("midrst_stays_idle", b4.out1, 0);
        b4.in_valid = 0;

        // Overflow on the 4096-beat instance
        bk.start = 1; step(); bk.start = 0;
        bk.in_valid = 1; bk.x_in = 8'sd127; bk.w_in = w_all;
        for (int i = 0; i < 4095; i++) step();
        check("ovf_sv_early", bk.score_valid, 0);
        step();
        bk.in_valid = 0;
        check("ovf_sv", bk.score_valid, 1);
        check("ovf_out1", bk.out1, ovf_exp);
        check("ovf_out5", bk.out5, ovf_exp);
        check("ovf_out10", bk.out10, ovf_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/output_layer_mac.md
# output_layer_mac

Sequential output-layer accumulator feeding the argmax (max-selector) stage. It streams one signed activation per accepted beat, together with the ten per-class signed weights for that activation. It multiply-accumulates into ten signed 26-bit class scores and presents them, with a valid flag, on ports out1..out10 that wire directly to the selector's score inputs.

## Interface
- N_IN, 784, number of activations per inference (1..4096)
- DATA_W, 8, activation width, signed
- WEIGHT_W, 8, weight width, signed
- ACC_W, 26, score/accumulator width, signed

Ports (reset is synchronous, active-high, sampled on rising edge of clk; single clock domain):
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse; clears scores and begins an inference
- in_valid  input  1  x_in/w_in valid
- in_ready  output  1  block accepts a beat this cycle
- x_in  input  DATA_W  signed activation
- w_in  input  10*WEIGHT_W  ten signed weights; class k (k=0..9) in bits [WEIGHT_W*k+WEIGHT_W-1 : WEIGHT_W*k]
- busy  output  1  inference in progress
- score_valid  output  1  out1..out10 hold final scores
- out1..out10  output  ACC_W each  signed class scores; outN corresponds to class N-1

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, busy=0, score_valid=0. On start: clear all ten accumulators and the beat counter, then go to ACCUM.
- ACCUM: in_ready=1, busy=1.
  - A beat is accepted when in_valid && in_ready.
  - Per accepted beat, every accumulator updates as acc_k <= acc_k + x_in * w_k.
  - The product is a full 16-bit signed product, sign-extended to ACC_W before the add.
  - No update occurs on cycles without an accepted beat.
- The beat counter is ceil(log2(N_IN)) bits, or 1 bit minimum. When the N_IN-th beat is accepted, go to DONE.
- DONE: in_ready=0, busy=0, score_valid=1. Scores are held stable until the next start, which clears and re-enters ACCUM.
- start while in ACCUM is ignored; the inference continues.
- start and in_valid in the same cycle from IDLE/DONE: no beat is accepted that cycle, because in_ready=0.
- Arithmetic:
  - Signed two's complement throughout.
  - Overflow behaviour is set by the Configuration section.
  - The default parameters cannot overflow: 784 × 127 × 128 < 2^25.
- rst in any state, including mid-ACCUM, forces IDLE. The partial inference is discarded.

## Timing
- Reset values: state=IDLE, all out1..out10=0, in_ready=0, busy=0, score_valid=0, beat counter=0.
- Cycle of start: registered next edge. in_ready rises the cycle after start is sampled.
- Accumulate latency: 1 cycle. acc reflects a beat at the edge that accepts it.
- The N_IN-th accepted beat and the transition to DONE occur on the same edge, so score_valid=1 with final scores in the following cycle.
- Minimum inference time: 1 (start) + N_IN cycles to score_valid.
- score_valid drops the cycle after start is sampled in DONE. out1..out10 read 0 from that cycle.
- Stalls (in_valid=0) during ACCUM extend the inference cycle-for-cycle. There is no timeout.

## Configuration
- OUTLAYER_SAT_EN defined:
  - each accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], i.e. [-33554432, 33554431] for ACC_W=26;
  - a saturated accumulator stays clamped unless later beats bring it back into range through normal addition from the clamped value.
- OUTLAYER_SAT_EN undefined: the add wraps modulo 2^ACC_W.

## Test plan
- Basic: N_IN=4, x=1,2,3,4.
  - Class 0 weights all 1, class 1 all -1, class 9 all 127, others 0.
  - Required: out1=10, out2=-10, out10=1270, others 0.
  - score_valid is high 5 cycles after start, with in_valid held high.
- Backpressure/stall: same stimulus with in_valid low for 3 cycles between beats 2 and 3.
  - Required: identical scores; score_valid delayed by exactly 3 cycles; no accumulation during stalls.
- Restart: after DONE, pulse start, then feed N_IN=4 beats of x=-2 with class 4 weight 5.
  - Required: out1..out10 read 0 the cycle after start.
  - Final out5=-40.
  - score_valid stays low until the fourth beat is accepted.
- Ignored start / mid-run reset:
  - start pulsed after beat 2 has no effect; scores are as in Basic.
  - Separately, rst after beat 2: all outputs 0 and state IDLE the next cycle; in_ready=0.
- Overflow: N_IN=4096, x=127, all weights 127 (sum 66064384).
  - Required with OUTLAYER_SAT_EN: all outN=33554431.
  - Required without it: all outN=-1044480.
